// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the EX stage.
// One operation at a time: a sign-stripping PREP cycle, XLEN single-bit
// CALC cycles (shift-add multiply or restoring divide), then a FIX cycle
// that restores signs and selects the result. Divide-by-zero and signed
// overflow finish immediately. All outputs come straight from flops.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int ACC_W = 2 * XLEN;
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [XLEN-1:0]  XZERO    = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  XONES    = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [ACC_W-1:0] AZERO    = {ACC_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Two's complement negation of an XLEN-bit value (wraps for the minimum).
    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Two's complement negation of a full double-width product.
    function automatic logic [ACC_W-1:0] neg_acc(input logic [ACC_W-1:0] v);
        return ~v + {{(ACC_W-1){1'b0}}, 1'b1};
    endfunction

    // rs1 is signed for MUL, MULH, MULHSU, DIV, REM.
    function automatic logic a_is_signed(input logic [2:0] f3);
        logic r;
        case (f3)
            3'b000, 3'b001, 3'b010: r = 1'b1;
            3'b100, 3'b110:         r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // rs2 is signed for MUL, MULH, DIV, REM.
    function automatic logic b_is_signed(input logic [2:0] f3);
        logic r;
        case (f3)
            3'b000, 3'b001:  r = 1'b1;
            3'b100, 3'b110:  r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [XLEN-1:0]    a_q, a_d;
    logic [XLEN-1:0]    b_q, b_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Datapath helpers
    logic               is_div_s;
    logic               a_neg_s, b_neg_s;
    logic [XLEN-1:0]    a_mag_s, b_mag_s;
    logic [XLEN:0]      mul_sum_s;
    logic [ACC_W-1:0]   mul_step_s;
    logic [XLEN:0]      div_shift_s;
    logic [XLEN:0]      div_diff_s;
    logic [ACC_W-1:0]   div_step_s;
    logic [ACC_W-1:0]   prod_s;
    logic [XLEN-1:0]    quot_s, rem_s;
    logic [XLEN-1:0]    fix_res_s;
    logic               in_zero_s, in_ovf_s, in_special_s;
    logic [XLEN-1:0]    special_res_s;

    assign is_div_s = op_q[2];

    // Magnitudes of the latched operands, used in PREP.
    assign a_neg_s = a_is_signed(op_q) & a_q[XLEN-1];
    assign b_neg_s = b_is_signed(op_q) & b_q[XLEN-1];
    assign a_mag_s = a_neg_s ? neg_x(a_q) : a_q;
    assign b_mag_s = b_neg_s ? neg_x(b_q) : b_q;

    // Multiply step: acc = {partial high, remaining multiplier bits}.
    assign mul_sum_s  = {1'b0, acc_q[ACC_W-1:XLEN]}
                      + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    assign mul_step_s = {mul_sum_s, acc_q[XLEN-1:1]};

    // Restoring divide step: acc = {partial remainder, dividend/quotient bits}.
    assign div_shift_s = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-1]};
    assign div_diff_s  = div_shift_s - {1'b0, b_q};
    assign div_step_s  = div_diff_s[XLEN]
                       ? {div_shift_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                       : {div_diff_s[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

    // Sign correction applied in FIX.
    assign prod_s = neg_res_q ? neg_acc(acc_q) : acc_q;
    assign quot_s = neg_res_q ? neg_x(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    assign rem_s  = neg_rem_q ? neg_x(acc_q[ACC_W-1:XLEN]) : acc_q[ACC_W-1:XLEN];

    // Early-exit detection on the incoming request.
    assign in_zero_s    = funct3_i[2] & (operand_b_i == XZERO);
    assign in_ovf_s     = funct3_i[2] & ~funct3_i[0]
                        & (operand_a_i == XMIN) & (operand_b_i == XONES);
    assign in_special_s = in_zero_s | in_ovf_s;

    // Result of a divide-by-zero or signed-overflow request.
    always_comb begin
        special_res_s = XZERO;
        if (in_zero_s) begin
            special_res_s = funct3_i[1] ? operand_a_i : XONES;
        end else begin
            special_res_s = funct3_i[1] ? XZERO : operand_a_i;
        end
    end

    // Select the final result from the corrected product/quotient/remainder.
    always_comb begin
        fix_res_s = XZERO;
        case (op_q)
            3'b000:                 fix_res_s = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res_s = prod_s[ACC_W-1:XLEN];
            3'b100, 3'b101:         fix_res_s = quot_s;
            3'b110, 3'b111:         fix_res_s = rem_s;
            default:                fix_res_s = XZERO;
        endcase
    end

    // Next-state and datapath control; FLUSH overrides everything at the end.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    op_d      = funct3_i;
                    a_d       = operand_a_i;
                    b_d       = operand_b_i;
                    neg_res_d = 1'b0;
                    neg_rem_d = 1'b0;
                    acc_d     = AZERO;
                    cnt_d     = CNT_ZERO;
                    if (in_special_s) begin
                        result_d = special_res_s;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_PREP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                a_d       = a_mag_s;
                b_d       = b_mag_s;
                neg_res_d = a_neg_s ^ b_neg_s;
                neg_rem_d = a_neg_s;
                acc_d     = is_div_s ? {XZERO, a_mag_s} : {XZERO, b_mag_s};
                cnt_d     = CNT_LAST;
                state_d   = S_CALC;
            end
            S_CALC: begin
                acc_d = is_div_s ? div_step_s : mul_step_s;
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_FIX: begin
                result_d = fix_res_s;
                state_d  = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end else begin
            state_d  = state_d;
        end
    end

    // Registered status flags derived from the upcoming state.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_PREP, S_CALC, S_FIX: busy_d = 1'b1;
            S_DONE:                done_d = 1'b1;
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= 3'b000;
            a_q       <= XZERO;
            b_q       <= XZERO;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= AZERO;
            cnt_q     <= CNT_ZERO;
            result_q  <= XZERO;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table driven through a scoreboard, plus
// hand-written sequences for flush, busy-START, back-to-back, reset and XLEN=16.
module tb_muldiv_unit;

    localparam int NL = 34;   // normal latency in edges after E0 for XLEN=32

    logic        clk, rst;
    logic        start, flush;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    logic        start16, flush16;
    logic [2:0]  f3_16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [15:0] result16;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .funct3_i(f3),
        .operand_a_i(a), .operand_b_i(b), .flush_i(flush),
        .busy_o(busy), .done_o(done), .result_o(result)
    );

    muldiv_unit #(.XLEN(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .funct3_i(f3_16),
        .operand_a_i(a16), .operand_b_i(b16), .flush_i(flush16),
        .busy_o(busy16), .done_o(done16), .result_o(result16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    task automatic add_vec(input string nm, input logic [2:0] f, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] r, input int l);
        vec_t v;
        v.name = nm; v.f3 = f; v.a = av; v.b = bv; v.res = r; v.lat = l;
        vecs.push_back(v);
    endtask

    task automatic sb_push(input string nm, input logic [31:0] r, input int l);
        exp_t e;
        e.name = nm; e.res = r; e.lat = l;
        sb.push_back(e);
    endtask

    task automatic drive_start(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1; f3 = f; a = av; b = bv;
    endtask

    // Wait for DONE of the request currently on the inputs; compare against scoreboard.
    // inject_k >= 0 raises a spurious START at that sample while the unit is busy.
    task automatic collect(input int inject_k);
        int   k;
        int   busy_n;
        bit   seen;
        exp_t e;
        @(posedge clk); #1;
        start = 1'b0; k = 0; busy_n = 0; seen = 1'b0;
        while (!seen && k < 100) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) busy_n++;
                if (k == inject_k) begin
                    start = 1'b1; f3 = 3'b000; a = 32'd3; b = 32'd3;
                end else if (k == inject_k + 1) begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                k++;
            end
        end
        if (sb.size() == 0) begin
            check("scoreboard empty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({e.name, " done"}, {63'd0, seen}, 64'd1);
            check({e.name, " result"}, {32'd0, result}, {32'd0, e.res});
            check({e.name, " latency"}, k, e.lat);
            check({e.name, " busy cycles"}, busy_n, e.lat);
            check({e.name, " busy at done"}, {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        int n_done;
        int k;

        rst = 1'b1; start = 1'b0; flush = 1'b0; f3 = 3'b000; a = 32'd0; b = 32'd0;
        start16 = 1'b0; flush16 = 1'b0; f3_16 = 3'b000; a16 = 16'd0; b16 = 16'd0;

        add_vec("MULH min*min",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, NL);
        add_vec("MULHU ones*ones",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NL);
        add_vec("MULHSU ones*ones", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NL);
        add_vec("MULH -1*1",        3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, NL);
        add_vec("MUL 0x12345678*9", 3'b000, 32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38, NL);
        add_vec("MULHU min*2",      3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, NL);
        add_vec("DIV -7/2",         3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, NL);
        add_vec("REM -7/2",         3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, NL);
        add_vec("DIVU 100/7",       3'b101, 32'd100,       32'd7,         32'd14,        NL);
        add_vec("REMU 100/7",       3'b111, 32'd100,       32'd7,         32'd2,         NL);
        add_vec("DIV 7/-2",         3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, NL);
        add_vec("REM 7/-2",         3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         NL);
        add_vec("DIV min/2",        3'b100, 32'h8000_0000, 32'd2,         32'hC000_0000, NL);
        add_vec("REM min/1",        3'b110, 32'h8000_0000, 32'd1,         32'd0,         NL);
        add_vec("DIVU min/ones",    3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         NL);
        add_vec("REMU min/ones",    3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, NL);
        add_vec("DIV 5/0",          3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
        add_vec("DIVU 5/0",         3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
        add_vec("REM 5/0",          3'b110, 32'd5,         32'd0,         32'd5,         0);
        add_vec("REMU 5/0",         3'b111, 32'd5,         32'd0,         32'd5,         0);
        add_vec("DIV ovf",          3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        add_vec("REM ovf",          3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy",   {63'd0, busy}, 64'd0);
        check("reset done",   {63'd0, done}, 64'd0);
        check("reset result", {32'd0, result}, 64'd0);
        rst = 1'b0;

        // MUL 7 * -3 with DONE pulse width and hold
        @(negedge clk);
        drive_start(3'b000, 32'd7, 32'hFFFF_FFFD);
        sb_push("MUL 7*-3", 32'hFFFF_FFEB, NL);
        collect(-1);
        @(posedge clk); #1;
        check("MUL done low after pulse", {63'd0, done}, 64'd0);
        check("MUL result held", {32'd0, result}, 64'h0000_0000_FFFF_FFEB);

        // Flush on the 10th CALC cycle
        @(negedge clk);
        drive_start(3'b000, 32'h0000_1234, 32'h0000_5678);
        @(posedge clk); #1; start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush busy",   {63'd0, busy}, 64'd0);
        check("flush done",   {63'd0, done}, 64'd0);
        check("flush result", {32'd0, result}, 64'h0000_0000_FFFF_FFEB);
        n_done = 0;
        repeat (40) begin @(posedge clk); #1; if (done) n_done++; end
        check("flush no late done", n_done, 0);
        check("flush result kept", {32'd0, result}, 64'h0000_0000_FFFF_FFEB);

        // Table of vectors
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive_start(vecs[i].f3, vecs[i].a, vecs[i].b);
            sb_push(vecs[i].name, vecs[i].res, vecs[i].lat);
            collect(-1);
        end

        // START while busy is ignored
        @(negedge clk);
        drive_start(3'b101, 32'd100, 32'd7);
        sb_push("busy-START DIVU", 32'd14, NL);
        collect(5);

        // Back-to-back: next START issued during each DONE cycle
        @(negedge clk);
        drive_start(3'b100, 32'hFFFF_FFF9, 32'd2);
        sb_push("b2b DIV", 32'hFFFF_FFFD, NL);
        collect(-1);
        drive_start(3'b111, 32'd100, 32'd7);
        sb_push("b2b REMU", 32'd2, NL);
        collect(-1);
        drive_start(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        sb_push("b2b REM ovf", 32'd0, 0);
        collect(-1);
        drive_start(3'b000, 32'd6, 32'd7);
        sb_push("b2b MUL", 32'd42, NL);
        collect(-1);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        drive_start(3'b000, 32'd9, 32'd9);
        @(posedge clk); #1; start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("async reset busy",   {63'd0, busy}, 64'd0);
        check("async reset done",   {63'd0, done}, 64'd0);
        check("async reset result", {32'd0, result}, 64'd0);
        @(negedge clk); rst = 1'b0;
        n_done = 0;
        repeat (40) begin @(posedge clk); #1; if (done) n_done++; end
        check("no done after reset", n_done, 0);

        // XLEN=16 instance
        @(negedge clk);
        start16 = 1'b1; f3_16 = 3'b101; a16 = 16'hFFFF; b16 = 16'h0010;
        @(posedge clk); #1; start16 = 1'b0;
        k = 0;
        while (!done16 && k < 60) begin @(posedge clk); #1; k++; end
        check("x16 DIVU result",  {48'd0, result16}, 64'h0000_0000_0000_0FFF);
        check("x16 DIVU latency", k, 18);

        check("scoreboard drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative RV-M multiply/divide execution unit for the pipelined core's EX stage. It accepts one operation from ID_EX and computes the XLEN-bit result over multiple cycles. It signals completion with a one-cycle DONE pulse so the pipeline can hold its stages (BUSYWAIT-style) while BUSY is high. It replaces single-cycle ALU multiply/divide opcodes and adds MULH/MULHSU/MULHU, divide-by-zero and overflow semantics, and pipeline flush.

## Interface
- XLEN, 32: operand/result width; any even value ≥ 8.
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled in IDLE or DONE state only.
- FUNCT3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OPERAND_A  in  XLEN  rs1 value (multiplicand / dividend).
- OPERAND_B  in  XLEN  rs2 value (multiplier / divisor).
- FLUSH  in  1  synchronous abort of any in-flight operation.
- BUSY  out  1  high in PREP, CALC, FIX.
- DONE  out  1  one-cycle pulse; RESULT valid.
- RESULT  out  XLEN  result; held from DONE until next accepted START completes.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE/DONE + START (FLUSH low): latch FUNCT3 and operands, go to PREP. If it is a special case, go to DONE directly instead.
  - Special cases: DIV/DIVU/REM/REMU with B=0; DIV/REM with A=−2^(XLEN−1) and B=−1.
- DONE with no START -> IDLE.
- PREP: take magnitudes of signed operands and record result sign.
  - A is signed for MUL, MULH, MULHSU, DIV, REM.
  - B is signed for MUL, MULH, DIV, REM.
  - Load counter = XLEN−1, then go to CALC.
- CALC: one bit per cycle for XLEN cycles.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Counter 0 -> FIX.
- FIX: apply sign correction, then select the result.
  - MUL: low XLEN bits of the product.
  - MULH*: high XLEN bits of the product.
  - DIV*: quotient.
  - REM*: remainder.
  - Quotient is negated when the operand signs differ; remainder takes the dividend's sign.
  - Go to DONE.
- Special-case results:
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = A.
  - Overflow: DIV = A; REM = 0.
- START while BUSY: ignored, no effect on the operation in flight.
- FLUSH high at any edge: go to IDLE; no DONE; RESULT unchanged. FLUSH beats a simultaneous START.
- Arithmetic:
  - All intermediates are unsigned magnitudes.
  - Negation is two's complement, modulo 2^XLEN (−2^(XLEN−1) stays −2^(XLEN−1)).
  - MULHSU with negative A: negate the full 2·XLEN product before taking the high half.

## Timing
- Reset (asynchronous, immediate): state IDLE, BUSY=0, DONE=0, RESULT=0, counter=0, internal registers 0.
- Reset mid-operation abandons the operation; no DONE follows.
- Normal latency, counting E0 as the edge that samples START:
  - BUSY rises after E0.
  - DONE is high in the cycle after edge E0+XLEN+2 (34 edges for XLEN=32); BUSY falls at the same edge.
- Special-case latency: DONE is high in the cycle after E0; BUSY never rises.
- DONE is exactly one cycle wide. RESULT updates at the edge that raises DONE.
- Back-to-back: START during the DONE cycle is accepted, so there is no idle bubble; BUSY rises at the next edge.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- MUL, XLEN=32, A=7, B=0xFFFFFFFD:
  - BUSY high for 34 cycles.
  - DONE pulse at edge 34 with RESULT=0xFFFFFFEB.
  - DONE low the following cycle, RESULT held.
- High-half products:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
  - MULH 0xFFFFFFFF×1 -> 0xFFFFFFFF.
- Divide/remainder:
  - DIV −7/2 -> 0xFFFFFFFD.
  - REM −7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14, REMU -> 2.
  - DIV 7/−2 -> 0xFFFFFFFD, REM -> 1.
  - All complete in 34 edges.
- Special cases, each DONE one edge after START with BUSY never high:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Flush, busy-START and back-to-back:
  - FLUSH on the 10th CALC cycle of a MUL -> IDLE at that edge, no DONE, RESULT keeps its previous value.
  - START asserted while BUSY is ignored, and the original result completes unchanged.
  - START during a DONE cycle launches the next operation with no gap.
- Reset and width:
  - RESET asserted asynchronously mid-CALC -> BUSY/DONE/RESULT 0 before the next edge.
  - Separate XLEN=16 build: DIVU 0xFFFF/0x0010 -> 0x0FFF, DONE at edge 18.
